// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared definitions for the instruction-memory loader:
//                loader state encoding and frame-format constants.
//                The CHECK state exists only when IMEM_LOAD_CHECKSUM_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Frame format: a little-endian word count, then the payload packed
  // least-significant byte first.
  localparam int LOAD_BYTES_PER_WORD = 4;
  localparam int LOAD_COUNT_BYTES    = 2;

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } load_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } load_state_t;
`endif

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_word_packer
//  Description : Shifts accepted bytes into a 32-bit word, least-significant
//                byte first, and pulses o_word_ready combinationally in the
//                cycle the 4th byte of a word is accepted. o_word already
//                contains that 4th byte so the parent can register it on
//                the same edge.
//  Ports       : clk, reset_n      - clock, async active-low reset
//                i_clear           - restart at byte 0 (new load)
//                i_accept          - a payload byte is accepted this cycle
//                i_byte[7:0]       - the byte being accepted
//                o_word[31:0]      - assembled word including i_byte
//                o_word_ready      - 4th byte of a word accepted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  // Only the three most recent bytes need storing; the fourth arrives on
  // i_byte in the cycle the word completes.
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;
  logic [31:0] w_next;

  assign w_next       = {i_byte, r_shift};
  assign o_word       = w_next;
  assign o_word_ready = i_accept && (r_cnt == 2'(LOAD_BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_accept) begin
      r_shift <= w_next[31:8];
      r_cnt   <= r_cnt + 2'd1;  // wraps 3 -> 0 at the end of each word
    end
  end

endmodule : imem_word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a byte-stream frame (2-byte LE word count N, then
//                4*N payload bytes LSB first) and writes the assembled words
//                to an instruction memory at byte addresses 0,4,8,...
//                Holds the core while loading; reports done or error.
//                Optional feature macro IMEM_LOAD_CHECKSUM_EN: a trailing
//                XOR checksum byte over the payload is checked in CHECK.
//  Parameters  : WIDTH (32, fixed), SIZE (memory depth in words)
//  Ports       : clk, reset_n      - clock, async active-low reset
//                start             - pulse to begin a load (IDLE/DONE/ERR)
//                byte_in, byte_valid, byte_ready - byte stream handshake
//                instr_out, wr_addr, wr_en       - memory write port
//                core_hold         - core held while a load is in progress
//                done, error       - sticky completion status
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic [WIDTH-1:0]            instr_out,
  output logic [$clog2(SIZE)+1:0]     wr_addr,
  output logic                        wr_en,
  output logic                        core_hold,
  output logic                        done,
  output logic                        error
);

  localparam int LOGSIZE = $clog2(SIZE);

  load_state_t r_state;
  load_state_t w_next_state;

  logic               w_byte_ready;
  logic               w_accept;
  logic               w_pack_accept;
  logic               w_start_ok;
  logic               w_enter_done;
  logic               w_enter_err;
  logic [15:0]        w_count;
  logic [31:0]        w_word;
  logic               w_word_ready;

  logic [7:0]         r_count_lo;
  logic [LOGSIZE-1:0] r_last_idx;
  logic [LOGSIZE-1:0] r_word_idx;
  logic               r_wr_en;
  logic [WIDTH-1:0]   r_instr;
  logic [LOGSIZE+1:0] r_wr_addr;
  logic               r_core_hold;
  logic               r_done;
  logic               r_error;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]         r_xor;
`endif

  assign w_accept      = byte_valid && w_byte_ready;
  assign w_pack_accept = w_accept && (r_state == S_DATA);
  assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));
  // Full word count as seen while the high byte is on the bus.
  assign w_count       = {byte_in, r_count_lo};
  assign w_enter_done  = (w_next_state == S_DONE) && (r_state != S_DONE);
  assign w_enter_err   = (w_next_state == S_ERR)  && (r_state != S_ERR);

  imem_word_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_start_ok),
    .i_accept     (w_pack_accept),
    .i_byte       (byte_in),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_byte_ready = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_next_state = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        w_byte_ready = 1'b1;
        if (w_accept) begin
          w_next_state = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        w_byte_ready = 1'b1;
        if (w_accept) begin
          // Rejecting N>SIZE here is what keeps the address from wrapping.
          if ((w_count == 16'd0) || (w_count > 16'(SIZE))) begin
            w_next_state = S_ERR;
          end else begin
            w_next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_byte_ready = 1'b1;
        if (w_word_ready && (r_word_idx == r_last_idx)) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          w_next_state = S_CHECK;
`else
          w_next_state = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHECK: begin
        w_byte_ready = 1'b1;
        if (w_accept) begin
          w_next_state = (byte_in == r_xor) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: count capture, write port, status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count_lo  <= '0;
      r_last_idx  <= '0;
      r_word_idx  <= '0;
      r_wr_en     <= 1'b0;
      r_instr     <= '0;
      r_wr_addr   <= '0;
      r_core_hold <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_start_ok) begin
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_word_idx  <= '0;
        r_core_hold <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        r_xor       <= '0;
`endif
      end else begin
        if (w_accept && (r_state == S_CNT_LO)) begin
          r_count_lo <= byte_in;
        end
        if (w_accept && (r_state == S_CNT_HI)) begin
          // Only meaningful when 1<=N<=SIZE, in which case N-1 fits.
          r_last_idx <= LOGSIZE'(w_count - 16'd1);
        end
        // instr_out/wr_addr only move together with the write strobe.
        if (w_word_ready) begin
          r_wr_en    <= 1'b1;
          r_instr    <= w_word;
          r_wr_addr  <= {r_word_idx, 2'b00};
          r_word_idx <= r_word_idx + LOGSIZE'(1);
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        if (w_pack_accept) begin
          r_xor <= r_xor ^ byte_in;
        end
`endif
        if (w_enter_done) begin
          r_done      <= 1'b1;
          r_core_hold <= 1'b0;
        end
        if (w_enter_err) begin
          r_error     <= 1'b1;
          r_core_hold <= 1'b0;
        end
      end
    end
  end

  assign byte_ready = w_byte_ready;
  assign instr_out  = r_instr;
  assign wr_addr    = r_wr_addr;
  assign wr_en      = r_wr_en;
  assign core_hold  = r_core_hold;
  assign done       = r_done;
  assign error      = r_error;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Frame vectors are held
//                in a table; expected memory writes are queued when a frame
//                is driven and compared by a write monitor. Hand sequences
//                cover start-while-busy and reset in the middle of a load.
//                Honours IMEM_LOAD_CHECKSUM_EN for the trailing checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int SIZE  = 256;
  localparam int WIDTH = 32;
  localparam int AW    = $clog2(SIZE) + 2;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic [WIDTH-1:0] instr_out;
  logic [AW-1:0]   wr_addr;
  logic            wr_en;
  logic            core_hold;
  logic            done;
  logic            error;

  imem_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .instr_out  (instr_out),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;          // word count placed in the header
    int          nwords;     // payload words actually sent
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;        // idle cycles before every byte
    logic [7:0]  ck_flip;    // XOR applied to the correct checksum
    int          exp_writes;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int k);
    if (k == 0) return v.w0;
    if (k == 1) return v.w1;
    return v.w1 + (32'(k) * 32'h01010101);
  endfunction

  // Write monitor: every strobe must match the queue head; address and data
  // must not move while the strobe is low; done and error never both set.
  task automatic monitor();
    logic [AW-1:0] pa;
    logic [31:0]   pi;
    bit            pv;
    wr_t           e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pv = 1'b0;
        continue;
      end
      if (done && error) check("done_and_error", 32'(done & error), 32'd0);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr_addr", 32'(wr_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("instr_out", instr_out, e.data);
        end
      end else if (pv) begin
        if (wr_addr !== pa)   check("wr_addr_stable", 32'(wr_addr), 32'(pa));
        if (instr_out !== pi) check("instr_out_stable", instr_out, pi);
      end
      pa = wr_addr;
      pi = instr_out;
      pv = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready) begin
      if (t >= 50) begin
        fail_timeout("byte_ready");
        break;
      end
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input logic exp_done, input logic exp_err, input string tag);
    int t;
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) fail_timeout({tag, "_end"});
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_core_hold"}, 32'(core_hold), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [31:0] w;
    logic [7:0]  ck;
    ck = 8'h00;
    for (int k = 0; k < v.exp_writes; k++)
      exp_q.push_back('{addr: AW'(4 * k), data: word_of(v, k)});
    pulse_start();
    check({tag, "_hold_after_start"}, 32'(core_hold), 32'd1);
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    check({tag, "_error_cleared"}, 32'(error), 32'd0);
    send_byte(v.n[7:0], v.gap);
    send_byte(v.n[15:8], v.gap);
    for (int k = 0; k < v.nwords; k++) begin
      w = word_of(v, k);
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], v.gap);
        ck = ck ^ w[8*b +: 8];
      end
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    if (v.nwords > 0) send_byte(ck ^ v.ck_flip, v.gap);
`else
    if (ck === 8'hxx) check({tag, "_ck_unknown"}, 32'(ck), 32'd0);
`endif
    wait_end(v.exp_done, v.exp_err, tag);
  endtask

  initial begin
    vec_t v;
    // n, nwords, w0, w1, gap, ck_flip, exp_writes, done, err
    vecs.push_back('{16'd2,   2,   32'h00000513, 32'h00100093, 0, 8'h00, 2,   1'b1, 1'b0});
    vecs.push_back('{16'd0,   0,   32'h0,        32'h0,        0, 8'h00, 0,   1'b0, 1'b1});
    vecs.push_back('{16'd257, 0,   32'h0,        32'h0,        0, 8'h00, 0,   1'b0, 1'b1});
    vecs.push_back('{16'd2,   2,   32'h00000513, 32'h00100093, 3, 8'h00, 2,   1'b1, 1'b0});
    vecs.push_back('{16'd1,   1,   32'hDEADBEEF, 32'h0,        1, 8'h00, 1,   1'b1, 1'b0});
    vecs.push_back('{16'd3,   3,   32'h8BADF00D, 32'h12345678, 2, 8'h00, 3,   1'b1, 1'b0});
    vecs.push_back('{16'd256, 256, 32'hA5A5A5A5, 32'h5A5A0001, 0, 8'h00, 256, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 0,  32'h0,        32'h0,        0, 8'h00, 0,   1'b0, 1'b1});
`ifdef IMEM_LOAD_CHECKSUM_EN
    vecs.push_back('{16'd1,   1,   32'h00000513, 32'h0,        0, 8'h00, 1,   1'b1, 1'b0});
    vecs.push_back('{16'd1,   1,   32'h00000513, 32'h0,        0, 8'h01, 1,   1'b0, 1'b1});
`endif

    reset_n    = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Start pulses while busy must be ignored.
    v = vecs[0];
    exp_q.push_back('{addr: AW'(0), data: v.w0});
    exp_q.push_back('{addr: AW'(4), data: v.w1});
    pulse_start();
    send_byte(8'd2, 0);
    pulse_start();
    send_byte(8'd0, 0);
    for (int b = 0; b < 4; b++) send_byte(v.w0[8*b +: 8], 0);
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(v.w1[8*b +: 8], 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(v.w0[7:0] ^ v.w0[15:8] ^ v.w0[23:16] ^ v.w0[31:24] ^
              v.w1[7:0] ^ v.w1[15:8] ^ v.w1[23:16] ^ v.w1[31:24], 0);
`endif
    wait_end(1'b1, 1'b0, "busy_start");

    // Reset after 5 payload bytes: one write, then everything at reset values.
    exp_q.push_back('{addr: AW'(0), data: v.w0});
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    for (int b = 0; b < 4; b++) send_byte(v.w0[8*b +: 8], 0);
    send_byte(v.w1[7:0], 0);
    check("midrst_write_seen", 32'(exp_q.size()), 32'd0);
    check("midrst_hold_before", 32'(core_hold), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_byte_ready", 32'(byte_ready), 32'd0);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_core_hold", 32'(core_hold), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_instr_out", instr_out, 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_byte_ready", 32'(byte_ready), 32'd0);
    check("postrst_done", 32'(done), 32'd0);
    run_frame(vecs[0], "after_rst");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
